// File: rtl/alu_pair_if.sv
// Dispatch and result-broadcast bundle for the two independent lanes of alu_pair.
// The reservation station is the master; the execution unit is the slave.
interface alu_pair_if #(
    parameter int ROB_WIDTH = 4
);
    // Handshake: busy_alu_N is a valid with no ready, so the unit takes every
    // dispatch on an enabled edge. done_alu_N is a valid with no ready, and a
    // result is consumed on each rising edge with rdy_in high.
    logic                 busy_alu_1;
    logic [3:0]           opcode_alu_1;
    logic [31:0]          lhs_alu_1;
    logic [31:0]          rhs_alu_1;
    logic [ROB_WIDTH-1:0] rd_tag_alu_1;
    logic                 busy_alu_2;
    logic [3:0]           opcode_alu_2;
    logic [31:0]          lhs_alu_2;
    logic [31:0]          rhs_alu_2;
    logic [ROB_WIDTH-1:0] rd_tag_alu_2;

    logic                 done_alu_1;
    logic [31:0]          value_alu_1;
    logic [ROB_WIDTH-1:0] tag_alu_1;
    logic                 done_alu_2;
    logic [31:0]          value_alu_2;
    logic [ROB_WIDTH-1:0] tag_alu_2;

    modport master (
        output busy_alu_1, opcode_alu_1, lhs_alu_1, rhs_alu_1, rd_tag_alu_1,
        output busy_alu_2, opcode_alu_2, lhs_alu_2, rhs_alu_2, rd_tag_alu_2,
        input  done_alu_1, value_alu_1, tag_alu_1,
        input  done_alu_2, value_alu_2, tag_alu_2
    );

    modport slave (
        input  busy_alu_1, opcode_alu_1, lhs_alu_1, rhs_alu_1, rd_tag_alu_1,
        input  busy_alu_2, opcode_alu_2, lhs_alu_2, rhs_alu_2, rd_tag_alu_2,
        output done_alu_1, value_alu_1, tag_alu_1,
        output done_alu_2, value_alu_2, tag_alu_2
    );
endinterface

// File: rtl/alu_pair.sv
// Dual-lane integer execution unit. Each lane registers one result per dispatch
// and broadcasts it one cycle later. The two lanes share no state.
module alu_pair #(
    parameter int ROB_WIDTH = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       clear_signal,
    alu_pair_if.slave  bus
);
    function automatic logic [31:0] alu_f(input logic [3:0] op,
                                          input logic [31:0] l,
                                          input logic [31:0] r);
        logic [31:0] res;
        logic [4:0]  sh;
        res = '0;
        sh  = r[4:0];
        case (op)
            4'd0:    res = l + r;
            4'd1:    res = l - r;
            4'd2:    res = l << sh;
            4'd3:    res = {31'd0, $signed(l) < $signed(r)};
            4'd4:    res = {31'd0, l < r};
            4'd5:    res = l ^ r;
            4'd6:    res = l >> sh;
            4'd7:    res = $signed(l) >>> sh;
            4'd8:    res = l | r;
            4'd9:    res = l & r;
            4'd10:   res = {31'd0, l == r};
            4'd11:   res = {31'd0, l != r};
            4'd12:   res = {31'd0, $signed(l) < $signed(r)};
            4'd13:   res = {31'd0, $signed(l) >= $signed(r)};
            4'd14:   res = {31'd0, l < r};
            default: res = {31'd0, l >= r};
        endcase
        return res;
    endfunction

    logic [1:0]           busy;
    logic [3:0]           opcode [2];
    logic [31:0]          lhs    [2];
    logic [31:0]          rhs    [2];
    logic [ROB_WIDTH-1:0] rd_tag [2];

    assign busy      = {bus.busy_alu_2, bus.busy_alu_1};
    assign opcode[0] = bus.opcode_alu_1;
    assign opcode[1] = bus.opcode_alu_2;
    assign lhs[0]    = bus.lhs_alu_1;
    assign lhs[1]    = bus.lhs_alu_2;
    assign rhs[0]    = bus.rhs_alu_1;
    assign rhs[1]    = bus.rhs_alu_2;
    assign rd_tag[0] = bus.rd_tag_alu_1;
    assign rd_tag[1] = bus.rd_tag_alu_2;

    logic [1:0]           done_q, done_d;
    logic [31:0]          value_q [2];
    logic [31:0]          value_d [2];
    logic [ROB_WIDTH-1:0] tag_q   [2];
    logic [ROB_WIDTH-1:0] tag_d   [2];

    // A flush drops only done; value and tag keep their old contents.
    always_comb begin
        done_d = done_q;
        for (int i = 0; i < 2; i++) begin
            value_d[i] = value_q[i];
            tag_d[i]   = tag_q[i];
            if (rdy_in) begin
                if (clear_signal) begin
                    done_d[i] = 1'b0;
                end else if (busy[i]) begin
                    done_d[i]  = 1'b1;
                    value_d[i] = alu_f(opcode[i], lhs[i], rhs[i]);
                    tag_d[i]   = rd_tag[i];
                end else begin
                    done_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            done_q <= '0;
            for (int i = 0; i < 2; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            done_q <= done_d;
            for (int i = 0; i < 2; i++) begin
                value_q[i] <= value_d[i];
                tag_q[i]   <= tag_d[i];
            end
        end
    end

    assign bus.done_alu_1  = done_q[0];
    assign bus.value_alu_1 = value_q[0];
    assign bus.tag_alu_1   = tag_q[0];
    assign bus.done_alu_2  = done_q[1];
    assign bus.value_alu_2 = value_q[1];
    assign bus.tag_alu_2   = tag_q[1];
endmodule

// File: tb/tb_alu_pair.sv
// Directed bench for alu_pair: expected {tag,value} pairs are queued at dispatch
// and popped by a monitor whenever a lane's result is consumed.
module tb_alu_pair;
    localparam int RW = 4;
    localparam int EW = RW + 32;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    logic clear_signal = 1'b0;

    alu_pair_if #(.ROB_WIDTH(RW)) bus ();

    alu_pair #(.ROB_WIDTH(RW)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear_signal (clear_signal),
        .bus          (bus)
    );

    // clock/reset block
    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad = 0;
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q2[$];
    logic [EW-1:0] pend1, pend2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive1(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r,
                          input logic [RW-1:0] tag, input logic [31:0] exp);
        bus.busy_alu_1 = 1'b1; bus.opcode_alu_1 = op;
        bus.lhs_alu_1 = l; bus.rhs_alu_1 = r; bus.rd_tag_alu_1 = tag;
        pend1 = {tag, exp};
    endtask

    task automatic drive2(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r,
                          input logic [RW-1:0] tag, input logic [31:0] exp);
        bus.busy_alu_2 = 1'b1; bus.opcode_alu_2 = op;
        bus.lhs_alu_2 = l; bus.rhs_alu_2 = r; bus.rd_tag_alu_2 = tag;
        pend2 = {tag, exp};
    endtask

    task automatic idle();
        bus.busy_alu_1 = 1'b0;
        bus.busy_alu_2 = 1'b0;
    endtask

    // One rising edge; only dispatches the DUT should accept are queued.
    task automatic tick();
        logic acc;
        acc = !rst_in && rdy_in && !clear_signal;
        @(posedge clk_in);
        if (acc && bus.busy_alu_1) exp_q1.push_back(pend1);
        if (acc && bus.busy_alu_2) exp_q2.push_back(pend2);
        #1;
    endtask

    // scoreboard monitor: a result is consumed at the edge following this negedge
    always @(negedge clk_in) begin
        if (!rst_in && rdy_in) begin
            if (bus.done_alu_1) begin
                if (exp_q1.size() == 0) begin
                    check("lane1_unexpected_done", 64'(bus.done_alu_1), 64'd0);
                end else begin
                    check("lane1_result", 64'({bus.tag_alu_1, bus.value_alu_1}), 64'(exp_q1.pop_front()));
                end
            end
            if (bus.done_alu_2) begin
                if (exp_q2.size() == 0) begin
                    check("lane2_unexpected_done", 64'(bus.done_alu_2), 64'd0);
                end else begin
                    check("lane2_result", 64'({bus.tag_alu_2, bus.value_alu_2}), 64'(exp_q2.pop_front()));
                end
            end
        end
    end

    initial begin
        idle();
        pend1 = '0;
        pend2 = '0;
        bus.opcode_alu_1 = '0; bus.lhs_alu_1 = '0; bus.rhs_alu_1 = '0; bus.rd_tag_alu_1 = '0;
        bus.opcode_alu_2 = '0; bus.lhs_alu_2 = '0; bus.rhs_alu_2 = '0; bus.rd_tag_alu_2 = '0;

        // Reset with a dispatch present: it must be dropped.
        rst_in = 1'b1;
        drive1(4'd0, 32'd1, 32'd1, 4'd9, 32'd2);
        tick();
        tick();
        check("reset_done1", 64'(bus.done_alu_1), 64'd0);
        check("reset_done2", 64'(bus.done_alu_2), 64'd0);
        check("reset_value1", 64'(bus.value_alu_1), 64'd0);
        check("reset_value2", 64'(bus.value_alu_2), 64'd0);
        check("reset_tag1", 64'(bus.tag_alu_1), 64'd0);
        check("reset_tag2", 64'(bus.tag_alu_2), 64'd0);
        rst_in = 1'b0;
        idle();
        tick();

        // ADD wraps modulo 2^32
        drive1(4'd0, 32'hFFFF_FFFF, 32'h0000_0002, 4'd5, 32'h0000_0001);
        tick();
        check("add_done1", 64'(bus.done_alu_1), 64'd1);
        idle();
        tick();
        check("add_done1_falls", 64'(bus.done_alu_1), 64'd0);

        // Shifts and compares on lane 2, back to back
        drive2(4'd7, 32'h8000_0000, 32'h0000_0024, 4'd1, 32'hF800_0000); tick();
        drive2(4'd6, 32'h8000_0000, 32'h0000_0024, 4'd2, 32'h0800_0000); tick();
        drive2(4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3, 32'd1); tick();
        drive2(4'd4, 32'hFFFF_FFFF, 32'h0000_0001, 4'd4, 32'd0); tick();
        drive2(4'd15, 32'd5, 32'd5, 4'd5, 32'd1); tick();
        idle();
        tick();
        check("lane2_done_falls", 64'(bus.done_alu_2), 64'd0);

        // Both lanes every cycle for 4 cycles
        drive1(4'd1, 32'd10, 32'd3, 4'd1, 32'd7);
        drive2(4'd5, 32'h0000_F0F0, 32'h0000_0FF0, 4'd2, 32'h0000_FF00); tick();
        check("b2b_done1_c1", 64'(bus.done_alu_1), 64'd1);
        drive1(4'd2, 32'd1, 32'h0000_0021, 4'd3, 32'd2);
        drive2(4'd8, 32'h0000_00F0, 32'h0000_0F00, 4'd3, 32'h0000_0FF0); tick();
        drive1(4'd10, 32'd7, 32'd7, 4'd4, 32'd1);
        drive2(4'd11, 32'd7, 32'd7, 4'd5, 32'd0); tick();
        drive1(4'd12, 32'h8000_0000, 32'd0, 4'd6, 32'd1);
        drive2(4'd14, 32'h8000_0000, 32'd0, 4'd7, 32'd0); tick();
        check("b2b_done2_c4", 64'(bus.done_alu_2), 64'd1);
        idle();
        tick();
        check("b2b_done1_falls", 64'(bus.done_alu_1), 64'd0);
        check("b2b_done2_falls", 64'(bus.done_alu_2), 64'd0);

        // rdy_in stall holds a pending result and ignores new dispatches
        drive1(4'd9, 32'h0000_FF00, 32'h0000_0FF0, 4'd3, 32'h0000_0F00);
        tick();
        rdy_in = 1'b0;
        drive1(4'd0, 32'd100, 32'd200, 4'd12, 32'd300);
        drive2(4'd0, 32'd1, 32'd2, 4'd13, 32'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_held1", 64'({bus.done_alu_1, bus.tag_alu_1, bus.value_alu_1}),
                  64'({1'b1, 4'd3, 32'h0000_0F00}));
            check("stall_done2", 64'(bus.done_alu_2), 64'd0);
        end
        idle();
        rdy_in = 1'b1;
        tick();

        // Flush: the N-1 result shows once, the dispatch at N is discarded
        drive1(4'd0, 32'd1, 32'd1, 4'd8, 32'd2);
        drive2(4'd13, 32'hFFFF_FFFF, 32'd0, 4'd9, 32'd0);
        tick();
        drive1(4'd0, 32'd3, 32'd3, 4'd10, 32'd6);
        drive2(4'd1, 32'd9, 32'd4, 4'd11, 32'd5);
        clear_signal = 1'b1;
        tick();
        check("flush_done1", 64'(bus.done_alu_1), 64'd0);
        check("flush_done2", 64'(bus.done_alu_2), 64'd0);
        clear_signal = 1'b0;
        idle();
        tick();

        // Flush ignored while rdy_in is low
        drive1(4'd5, 32'd1, 32'd3, 4'd11, 32'd2);
        tick();
        rdy_in = 1'b0;
        clear_signal = 1'b1;
        drive1(4'd0, 32'd4, 32'd4, 4'd1, 32'd8);
        tick();
        check("clear_nordy_held1", 64'({bus.done_alu_1, bus.tag_alu_1, bus.value_alu_1}),
              64'({1'b1, 4'd11, 32'd2}));
        rdy_in = 1'b1;
        clear_signal = 1'b0;
        idle();
        tick();
        tick();
        tick();

        check("lane1_queue_drained", 64'(exp_q1.size()), 64'd0);
        check("lane2_queue_drained", 64'(exp_q2.size()), 64'd0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_pair.md
# alu_pair

Dual-lane integer execution unit on the dispatch side of the reservation station. Each lane accepts one operation per cycle from the station's ALU dispatch port and returns a registered result on its result broadcast bus one cycle later. The result buses (done/value/tag) fan out to the reservation station, load/store buffer and reorder buffer for wakeup and commit. Both lanes are identical and fully independent; neither lane stalls.

## Interface
Parameters:
- ROB_WIDTH, 4, width of reorder-buffer tags carried through each lane.

Ports (one clock; reset is synchronous and active-high):
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global enable; when low, all state holds.
- clear_signal  input  1  misprediction flush; kills in-flight results.
- busy_alu_1 / busy_alu_2  input  1  dispatch valid for lane 1 / lane 2.
- opcode_alu_1 / opcode_alu_2  input  4  operation select.
- lhs_alu_1 / lhs_alu_2  input  32  left operand.
- rhs_alu_1 / rhs_alu_2  input  32  right operand.
- rd_tag_alu_1 / rd_tag_alu_2  input  ROB_WIDTH  destination ROB tag.
- done_alu_1 / done_alu_2  output  1  result valid this cycle.
- value_alu_1 / value_alu_2  output  32  result value.
- tag_alu_1 / tag_alu_2  output  ROB_WIDTH  result ROB tag; equals the dispatched rd_tag.

## Operation
- Opcode map, L=lhs, R=rhs, shamt=R[4:0]:
  - 0 ADD: L+R mod 2^32.
  - 1 SUB: L-R mod 2^32.
  - 2 SLL: L<<shamt.
  - 3 SLT: signed L<R.
  - 4 SLTU: unsigned L<R.
  - 5 XOR.
  - 6 SRL: logical shift right.
  - 7 SRA: arithmetic shift right.
  - 8 OR.
  - 9 AND.
  - 10 EQ.
  - 11 NE.
  - 12 LT: signed.
  - 13 GE: signed.
  - 14 LTU.
  - 15 GEU.
- Compare opcodes (3, 4, 10-15) produce 32'd1 when true and 32'd0 when false.
- Each lane holds one output register set: done, value, tag.
- Per-lane update on rising edge, in priority order:
  - rst_in=1: done=0, value=0, tag=0 (both lanes).
  - else rdy_in=0: hold all registers.
  - else clear_signal=1: done=0; value and tag don't-care; the dispatch sampled this cycle is discarded.
  - else busy=1: done=1, value=f(opcode,L,R), tag=rd_tag.
  - else: done=0; value and tag hold.
- Lanes share no state. Simultaneous dispatch on both lanes, including identical tags, is legal and produces two independent results.
- No backpressure. A dispatch is accepted every enabled cycle.
- No internal state beyond the output registers.

## Timing
- Latency: 1 cycle. A dispatch sampled at edge N is visible as done=1 from edge N until edge N+1.
- done is a single-cycle pulse per dispatch unless the lane is dispatched again back-to-back. Back-to-back dispatches keep done=1 with a new value and tag each cycle.
- rdy_in low freezes done/value/tag. A pending result is re-presented unchanged once rdy_in returns high; consumers also freeze under rdy_in, so no result is lost or duplicated.
- clear_signal at edge N with rdy_in=1: done=0 after edge N, regardless of busy at N.
- clear_signal with rdy_in=0: ignored (hold).
- Reset mid-operation: outputs zero after the reset edge; a dispatch coincident with reset is dropped.
- Outputs depend only on registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst_in for 2 cycles with busy_alu_1=1 -> after reset, done_alu_1=done_alu_2=0, value=0, tag=0.
- Arithmetic:
  - Lane 1 ADD 0xFFFFFFFF+0x00000002, tag 5 -> next cycle done_alu_1=1, value_alu_1=0x00000001, tag_alu_1=5.
  - Following cycle with busy low -> done_alu_1=0.
- Shifts and compares on lane 2:
  - SRA 0x80000000 by R=0x00000024 (shamt 4) -> 0xF8000000.
  - SRL same operands -> 0x08000000.
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - SLTU same operands -> 0.
  - GEU 5 vs 5 -> 1.
- Back-to-back and dual lane:
  - Both lanes dispatch every cycle for 4 cycles (SUB 10-3 tag 1, XOR 0xF0F0 ^ 0x0FF0 tag 2, ...) -> done held high 4 cycles with correct per-cycle values (7, 0xFF00, ...) and tags.
  - Done falls the cycle after dispatch stops.
- rdy_in stall: dispatch AND 0xFF00 & 0x0FF0 tag 3, then rdy_in=0 for 3 cycles with new busy inputs -> done_alu_1=1, value 0x0F00, tag 3 held all 3 cycles; new inputs ignored.
- Flush:
  - Dispatch at edge N with clear_signal=1 -> done=0 after N.
  - Result of the dispatch at N-1 shows for one cycle only and is cleared at N.
  - clear_signal with rdy_in=0 -> outputs unchanged.
